// File: rtl/inst_cache_if.sv
// Fetch-side and physical-memory-side signals of the instruction cache.
// The cache takes the slave view; the fetch stage/memory model takes the master view.
interface inst_cache_if;
    logic         inst_read;
    logic [31:0]  inst_addr;
    logic         inst_resp;
    logic [31:0]  inst_rdata;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  inst_read, inst_addr, pmem_rdata, pmem_resp,
        output inst_resp, inst_rdata, pmem_read, pmem_address
    );

    modport master (
        output inst_read, inst_addr, pmem_rdata, pmem_resp,
        input  inst_resp, inst_rdata, pmem_read, pmem_address
    );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with single-request 256-bit line fills.
// Define ICACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module inst_cache #(
    parameter int S_INDEX  = 4,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    inst_cache_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
    localparam int NUM_SETS = 1 << S_INDEX;

    typedef enum logic [1:0] {IDLE, CHECK, FILL, RESP} state_t;

    state_t               state, state_next;
    logic [31:2]          req_addr;
    logic [NUM_SETS-1:0]  valid;
    logic [S_TAG-1:0]     tag_arr  [NUM_SETS];
    logic [255:0]         data_arr [NUM_SETS];
    logic [255:0]         fill_line;

    logic [S_TAG-1:0]     req_tag;
    logic [S_INDEX-1:0]   req_idx;
    logic [2:0]           req_word;
    logic                 hit;
    logic                 fill_done;
    logic                 unused_addr_bits;

    logic                 inst_resp;
    logic [31:0]          inst_rdata;
    logic                 pmem_read;
    logic [31:0]          pmem_address;

    assign req_tag          = req_addr[31 -: S_TAG];
    assign req_idx          = req_addr[S_OFFSET +: S_INDEX];
    assign req_word         = req_addr[4:2];
    assign hit              = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign fill_done        = (state == FILL) && bus.pmem_resp;
    assign unused_addr_bits = ^bus.inst_addr[1:0];

    // Only the valid bits need a reset; tag/data contents are meaningless while invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_addr <= '0;
            valid    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.inst_read)
                req_addr <= bus.inst_addr[31:2];
            if (fill_done)
                valid[req_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_arr[req_idx] <= bus.pmem_rdata;
            tag_arr[req_idx]  <= req_tag;
            fill_line         <= bus.pmem_rdata;
        end
    end

    always_comb begin
        state_next   = state;
        inst_resp    = 1'b0;
        inst_rdata   = '0;
        pmem_read    = 1'b0;
        pmem_address = '0;
        case (state)
            IDLE: begin
                if (bus.inst_read)
                    state_next = CHECK;
            end
            CHECK: begin
                if (hit) begin
                    inst_resp  = 1'b1;
                    inst_rdata = data_arr[req_idx][{req_word, 5'b00000} +: 32];
                    state_next = IDLE;
                end else begin
                    state_next = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, {S_OFFSET{1'b0}}};
                if (bus.pmem_resp)
                    state_next = RESP;
            end
            RESP: begin
                // A fetch abandoned during the fill still gets its line installed, but no answer.
                if (bus.inst_read) begin
                    inst_resp  = 1'b1;
                    inst_rdata = fill_line[{req_word, 5'b00000} +: 32];
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.inst_resp    = inst_resp;
    assign bus.inst_rdata   = inst_rdata;
    assign bus.pmem_read    = pmem_read;
    assign bus.pmem_address = pmem_address;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == CHECK) begin
            if (hit)
                hit_count <= hit_count + 32'd1;
            else
                miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios followed by randomized fetches
// compared against a scoreboard of installed lines.
module tb_inst_cache;
    logic clk = 1'b0;
    logic rst;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    inst_cache_if bus();

    inst_cache dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    // Reference model: what line, if any, each set is known to hold.
    bit           model_valid [16];
    logic [22:0]  model_tag   [16];
    logic [255:0] model_line  [16];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        bus.inst_read = 1'b0;
        bus.pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clearModel();
    endtask

    // One fetch from inst_read rise to completion, acting as both fetch stage and memory.
    task automatic applyStimulus(input logic [31:0] addr, input int delay, input bit drop,
                                 input bit use_line, input logic [255:0] given_line);
        logic [3:0]   idx;
        logic [22:0]  tag;
        logic [2:0]   word;
        logic [255:0] line;
        logic [31:0]  rdata, pmem_addr_seen;
        bit           exp_miss, exp_resp, saw_pmem, saw_resp, filled, done;
        int           cyc, resp_cyc, fill_cyc, post, drop_at;

        idx  = addr[8:5];
        tag  = addr[31:9];
        word = addr[4:2];
        exp_miss = !model_valid[idx] || (model_tag[idx] != tag);
        drop_at  = (drop && exp_miss && delay >= 1) ? 1 : -1;
        exp_resp = (drop_at < 0);
        if (use_line) line = given_line;
        else for (int w = 0; w < 8; w++) line[32*w +: 32] = $urandom;

        saw_pmem = 0; saw_resp = 0; filled = 0; done = 0;
        resp_cyc = 0; fill_cyc = 0; post = 0; rdata = 0; pmem_addr_seen = 0;

        @(negedge clk);
        bus.inst_read = 1'b1;
        bus.inst_addr = addr;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.pmem_resp = 1'b0;
            if (cyc == 2) bus.inst_addr = $urandom;
            if (bus.inst_resp) begin
                saw_resp = 1; resp_cyc = cyc; rdata = bus.inst_rdata; done = 1;
            end
            if (bus.pmem_read && !filled) begin
                if (!saw_pmem) pmem_addr_seen = bus.pmem_address;
                saw_pmem = 1;
                if (fill_cyc == drop_at) bus.inst_read = 1'b0;
                if (fill_cyc == delay) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = line;
                    filled = 1;
                end
                fill_cyc++;
            end else if (filled && !bus.inst_read) begin
                post++;
                if (post >= 3) done = 1;
            end
        end
        bus.inst_read = 1'b0;
        bus.pmem_resp = 1'b0;

        checkOutput("timeout", 32'(!done), 32'd0);
        checkOutput("miss", 32'(saw_pmem), 32'(exp_miss));
        if (exp_miss) checkOutput("pmem_addr", pmem_addr_seen, {addr[31:5], 5'b00000});
        if (exp_miss) begin
            model_valid[idx] = 1'b1;
            model_tag[idx]   = tag;
            model_line[idx]  = line;
        end
        checkOutput("resp", 32'(saw_resp), 32'(exp_resp));
        if (exp_resp) begin
            checkOutput("rdata", rdata, model_line[idx][32*word +: 32]);
            checkOutput("latency", 32'(resp_cyc), exp_miss ? 32'(4 + delay) : 32'd2);
        end
    endtask

    // A pmem_resp pulse while no fill is outstanding must not disturb the array.
    task automatic spuriousResp();
        @(negedge clk);
        bus.pmem_rdata = {8{$urandom}};
        bus.pmem_resp  = 1'b1;
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
    endtask

    logic [255:0] a_line;
    logic [255:0] no_line;
    bit           seen;

    initial begin
        rst = 1'b0;
        bus.inst_read  = 1'b0;
        bus.inst_addr  = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
        no_line = '0;
        for (int w = 0; w < 8; w++) a_line[32*w +: 32] = 32'hA0 + 32'(w);
        clearModel();

        repeat (2) @(negedge clk);
        checkOutput("rst_inst_resp", 32'(bus.inst_resp), 32'd0);
        checkOutput("rst_inst_rdata", bus.inst_rdata, 32'd0);
        checkOutput("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
        checkOutput("rst_pmem_address", bus.pmem_address, 32'd0);
        rst = 1'b1;

        $display("[TB] directed scenarios");
        applyStimulus(32'h0000_0060, 3, 0, 1, a_line);
        applyStimulus(32'h0000_006C, 0, 0, 0, no_line);
        applyStimulus(32'h0000_0260, 1, 0, 0, no_line);
        applyStimulus(32'h0000_0060, 0, 0, 1, a_line);
        applyStimulus(32'h0000_0080, 3, 1, 0, no_line);
        applyStimulus(32'h0000_0084, 0, 0, 0, no_line);
        spuriousResp();
        applyStimulus(32'h0000_0088, 0, 0, 0, no_line);

        // Reset while a fill for 0x100 is outstanding, then a stale pmem_resp.
        @(negedge clk);
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h0000_0100;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.pmem_read;
        end
        checkOutput("rst_fill_start", 32'(seen), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.inst_read = 1'b0;
        #1;
        checkOutput("rst_mid_fill_pmem_read", 32'(bus.pmem_read), 32'd0);
        clearModel();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.pmem_rdata = {8{$urandom}};
        bus.pmem_resp  = 1'b1;
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
        applyStimulus(32'h0000_0100, 2, 0, 0, no_line);
        applyStimulus(32'h0000_0060, 0, 0, 0, no_line);

        $display("[TB] randomized fetches");
        for (int n = 0; n < 80; n++) begin
            logic [31:0] addr;
            addr = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5)
                 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) spuriousResp();
            applyStimulus(addr, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 0, no_line);
        end

`ifdef ICACHE_STATS_EN
        $display("[TB] statistics counters");
        doReset();
        checkOutput("stats_rst_hit", hit_count, 32'd0);
        checkOutput("stats_rst_miss", miss_count, 32'd0);
        applyStimulus(32'h0000_0400, 1, 0, 0, no_line);
        applyStimulus(32'h0000_0404, 0, 0, 0, no_line);
        applyStimulus(32'h0000_0408, 0, 0, 0, no_line);
        @(negedge clk);
        checkOutput("stats_hit", hit_count, 32'd2);
        checkOutput("stats_miss", miss_count, 32'd1);
        force dut.hit_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_count;
        applyStimulus(32'h0000_040C, 0, 0, 0, no_line);
        @(negedge clk);
        checkOutput("stats_hit_wrap", hit_count, 32'd0);
        applyStimulus(32'h0000_0A00, 2, 1, 0, no_line);
        checkOutput("stats_drop_miss", miss_count, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
